// File: rtl/countdown_sequencer.sv
// Job-queue front end for the countdown timer: buffers presets, issues them one
// at a time, and reports each job as done or errored.
module countdown_sequencer #(
    parameter int WIDTH       = 7,
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       cd_start,
    output logic [WIDTH-1:0]           cd_preset,
    input  logic [WIDTH-1:0]           cd_count,
    input  logic                       cd_active,
    output logic                       job_done,
    output logic                       job_err,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

    localparam int LW   = $clog2(DEPTH + 1);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CMAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int CW   = (CMAX > 0) ? $clog2(CMAX + 1) : 1;

    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACT,
        RUN,
        GAP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [LW-1:0]    level_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic [WIDTH-1:0] head;
    logic             push;
    logic             pop;
    logic             done_next;
    logic             err_next;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Ready depends on level only: a full FIFO never accepts, even while popping.
    assign in_ready   = (level < LVL_FULL);
    assign push       = in_valid && in_ready;
    assign head       = mem[rd_ptr];
    assign fifo_level = level;
    assign busy       = (state != IDLE);
    assign cd_start   = (state == ISSUE);

    always_comb begin
        level_next = level;
        unique case ({push, pop})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        err_next   = 1'b0;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (level != '0) begin
                    pop = 1'b1;
                    if (head != '0) begin
                        state_next = ISSUE;
                    end else begin
                        // A zero preset needs no countdown run at all.
                        done_next  = 1'b1;
                        cnt_next   = '0;
                        state_next = GAP;
                    end
                end
            end
            ISSUE: begin
                cnt_next   = '0;
                state_next = WAIT_ACT;
            end
            WAIT_ACT: begin
                if (cd_active) begin
                    state_next = RUN;
                end else if (cnt == ACK_LAST) begin
                    err_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = GAP;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RUN: begin
                if (!cd_active) begin
                    // Stopping short of zero means the countdown was aborted.
                    if (cd_count == '0) begin
                        done_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                    cnt_next   = '0;
                    state_next = GAP;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            cd_preset <= '0;
            job_done  <= 1'b0;
            job_err   <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            level    <= level_next;
            job_done <= done_next;
            job_err  <= err_next;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr    <= ptr_inc(rd_ptr);
                cd_preset <= head;
            end
        end
    end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Scoreboard bench for countdown_sequencer with a behavioural countdown model.
// Expected events are queued at stimulus time and consumed by a negedge monitor.
module tb_countdown_sequencer;

    localparam int W   = 7;
    localparam int D   = 4;
    localparam int ACK = 4;
    localparam int GAP = 2;

    localparam int K_START = 0;
    localparam int K_DONE  = 1;
    localparam int K_ERR   = 2;

    localparam int M_IDEAL = 0;
    localparam int M_NEVER = 1;
    localparam int M_DROP  = 2;

    typedef struct {
        int kind;
        int val;
        int lat;
    } ev_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         cd_start;
    logic [W-1:0] cd_preset;
    logic [W-1:0] cd_count;
    logic         cd_active;
    logic         job_done;
    logic         job_err;
    logic         busy;
    logic [2:0]   fifo_level;

    logic         m_act;
    logic [W-1:0] m_cnt;
    int           mode;
    int           cyc;
    int           last_start;
    int           n_checks;
    int           n_fail;
    ev_t          sb[$];

    countdown_sequencer #(
        .WIDTH(W),
        .DEPTH(D),
        .ACK_TIMEOUT(ACK),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .cd_start(cd_start),
        .cd_preset(cd_preset),
        .cd_count(cd_count),
        .cd_active(cd_active),
        .job_done(job_done),
        .job_err(job_err),
        .busy(busy),
        .fifo_level(fifo_level)
    );

    assign cd_active = m_act;
    assign cd_count  = m_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Countdown model: active the cycle after start, P active cycles.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_act <= 1'b0;
            m_cnt <= '0;
        end else if (cd_start) begin
            if (mode != M_NEVER) begin
                m_act <= 1'b1;
                m_cnt <= cd_preset;
            end
        end else if (m_act) begin
            if (mode == M_DROP && m_cnt == 7'd5) begin
                m_cnt <= 7'd4;
                m_act <= 1'b0;
            end else if (m_cnt == 7'd1) begin
                m_cnt <= '0;
                m_act <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 7'd1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input int val, input int lat);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    task automatic handle(input int kind, input int val);
        ev_t e;
        int  dt;
        dt = cyc - last_start;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d, expected none", kind);
        end else begin
            e = sb.pop_front();
            check("event_kind", kind, e.kind);
            if (e.kind == K_START && kind == K_START) begin
                check("cd_preset", val, e.val);
            end
            if (e.lat >= 0) begin
                if (e.kind == K_START) begin
                    check("start_spacing_ok", int'(dt >= e.lat), 1);
                end else begin
                    check("event_latency", dt, e.lat);
                end
            end
        end
    endtask

    initial begin
        last_start = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cd_start) begin
                    handle(K_START, int'(cd_preset));
                    last_start = cyc;
                end
                if (job_done) begin
                    handle(K_DONE, 0);
                end
                if (job_err) begin
                    handle(K_ERR, 0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        in_valid = 1'b1;
        in_data  = W'(v);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || fifo_level != 0 || sb.size() != 0) && n < 300) begin
            step();
            n++;
        end
        check({tag, "_idle"}, int'(n < 300), 1);
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!cd_start && n < 50) begin
            step();
            n++;
        end
        check({tag, "_start_seen"}, int'(cd_start), 1);
    endtask

    initial begin
        int   n;
        int   b;
        logic acc;
        n_checks = 0;
        n_fail   = 0;
        mode     = M_IDEAL;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) step();

        check("rst_in_ready", int'(in_ready), 1);
        check("rst_cd_start", int'(cd_start), 0);
        check("rst_cd_preset", int'(cd_preset), 0);
        check("rst_job_done", int'(job_done), 0);
        check("rst_job_err", int'(job_err), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_fifo_level", int'(fifo_level), 0);

        // Push on the very first cycle out of reset, then a spaced second job.
        expect_ev(K_START, 5, -1);
        expect_ev(K_DONE, 0, 5 + 2);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 7'd5;
        step();
        in_valid = 1'b0;
        check("release_push_level", int'(fifo_level), 1);
        repeat (3) step();
        expect_ev(K_START, 10, 5 + GAP);
        expect_ev(K_DONE, 0, 10 + 2);
        push(10);
        wait_idle("two_jobs");

        // Fill the FIFO behind a long job; later jobs never see cd_active.
        expect_ev(K_START, 20, -1);
        expect_ev(K_DONE, 0, 20 + 2);
        push(20);
        wait_start("long_job");
        step();
        mode = M_NEVER;
        expect_ev(K_START, 7, -1);
        expect_ev(K_ERR, 0, ACK + 1);
        push(7);
        expect_ev(K_START, 8, -1);
        expect_ev(K_ERR, 0, ACK + 1);
        push(8);
        expect_ev(K_START, 9, -1);
        expect_ev(K_ERR, 0, ACK + 1);
        push(9);
        expect_ev(K_START, 11, -1);
        expect_ev(K_ERR, 0, ACK + 1);
        push(11);
        check("full_in_ready", int'(in_ready), 0);
        check("full_level", int'(fifo_level), 4);
        in_valid = 1'b1;
        in_data  = 7'd99;
        acc      = in_ready;
        step();
        in_valid = 1'b0;
        check("fifth_push_accepted", int'(acc), 0);
        check("full_level_after_fifth", int'(fifo_level), 4);
        n = 0;
        while (!in_ready && n < 60) begin
            step();
            n++;
        end
        check("ready_after_pop", int'(in_ready), 1);
        check("level_after_first_pop", int'(fifo_level), 3);
        check("start_on_first_pop", int'(cd_start), 1);
        wait_idle("fill");

        // Zero preset: no start, one done, busy only through the gap.
        mode = M_IDEAL;
        expect_ev(K_DONE, 0, -1);
        push(0);
        n = 0;
        while (!busy && n < 10) begin
            step();
            n++;
        end
        b = 0;
        while (busy && b < 20) begin
            b++;
            step();
        end
        check("zero_busy_cycles", b, GAP + 1);
        expect_ev(K_START, 3, -1);
        expect_ev(K_DONE, 0, 3 + 2);
        push(3);
        wait_idle("zero");

        // Reset in the middle of a run with two jobs waiting.
        expect_ev(K_START, 10, -1);
        push(10);
        wait_start("pre_reset");
        push(3);
        push(4);
        check("queued_before_rst", int'(fifo_level), 2);
        check("running_before_rst", int'(cd_active), 1);
        rst_n = 1'b0;
        sb.delete();
        step();
        check("mid_rst_level", int'(fifo_level), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_cd_start", int'(cd_start), 0);
        check("mid_rst_done", int'(job_done), 0);
        check("mid_rst_err", int'(job_err), 0);
        rst_n = 1'b1;
        n = 0;
        repeat (20) begin
            step();
            if (cd_start) n++;
        end
        check("no_start_after_rst", n, 0);

        // Countdown aborts at 4: error, then the next job runs normally.
        mode = M_DROP;
        expect_ev(K_START, 8, -1);
        expect_ev(K_ERR, 0, 6);
        expect_ev(K_START, 3, -1);
        expect_ev(K_DONE, 0, 3 + 2);
        push(8);
        push(3);
        wait_idle("drop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
